// File: rtl/bus_target_8086.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bus_target_8086 : minimum-mode 8086 bus target with RAM and wait states   |
// | Optional I/O register window enabled by defining BUS_IO_EN.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bus_target_8086 #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [19:0] BASE        = 20'h00000,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] IO_BASE     = 16'h0000,
  parameter int          IO_REGS     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ale,
  input  logic        m_ioN,
  input  logic        dt_rN,
  input  logic        bheN,
  input  logic        denN,
  input  logic        rdN,
  input  logic        wrN,
  input  logic [3:0]  as_in,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_DATA = 2'd3
  } state_t;

  localparam int IO_BITS = $clog2(IO_REGS);

  state_t      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic        bhe_n_q, bhe_n_d;
  logic        hit_q, hit_d;
  logic        is_io_q, is_io_d;
  logic        is_rd_q, is_rd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_done_q, wr_done_d;
  logic        both_low_q, both_low_d;
  logic        ready_q, ready_d;
  logic        ad_oe_q, ad_oe_d;
  logic        err_q, err_d;
  logic [15:0] ad_out_q, ad_out_d;

  logic [15:0] mem_q [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] mem_idx;
  logic [15:0] io_word;
  logic [15:0] rd_word;
  logic [19:0] lat_addr;
  logic        lat_bad, mem_dec, io_dec;
  logic        both_low, one_strobe, we;

  assign lat_addr   = {as_in, ad_in};
  assign lat_bad    = ad_in[0] & bheN;
  assign mem_dec    = m_ioN && (lat_addr[19:ADDR_BITS+1] == BASE[19:ADDR_BITS+1]);
  assign io_dec     = !m_ioN && (ad_in[15:IO_BITS+1] == IO_BASE[15:IO_BITS+1]);
  assign both_low   = !rdN && !wrN;
  assign one_strobe = rdN ^ wrN;
  assign mem_idx    = addr_q[ADDR_BITS:1];
  assign we         = (state_q == S_DATA) && !is_rd_q && !wr_done_q && !both_low && !reset;

`ifdef BUS_IO_EN
  localparam bit IO_ENABLE = 1'b1;
  logic [15:0] io_q [IO_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < IO_REGS; i++) io_q[i] <= '0;
    end else if (we && is_io_q) begin
      if (!addr_q[0]) io_q[addr_q[IO_BITS:1]][7:0]  <= ad_in[7:0];
      if (!bhe_n_q)   io_q[addr_q[IO_BITS:1]][15:8] <= ad_in[15:8];
    end
  end

  assign io_word = io_q[addr_q[IO_BITS:1]];
`else
  localparam bit IO_ENABLE = 1'b0;
  assign io_word = 16'h0000;
`endif

  assign rd_word = (IO_ENABLE && is_io_q) ? io_word : mem_q[mem_idx];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bhe_n_d    = bhe_n_q;
    hit_d      = hit_q;
    is_io_d    = is_io_q;
    is_rd_d    = is_rd_q;
    cnt_d      = cnt_q;
    wr_done_d  = 1'b0;
    err_d      = 1'b0;
    both_low_d = both_low;

    if (both_low) begin
      // Conflicting strobes abort whatever was in flight; pulse once per event.
      err_d   = !both_low_q;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ADDR: begin
          if (ale) begin
            addr_d  = lat_addr;
            bhe_n_d = bheN;
            is_io_d = !m_ioN;
            hit_d   = (mem_dec || (IO_ENABLE && io_dec)) && !lat_bad;
            err_d   = lat_bad;
            state_d = S_ADDR;
          end else if (state_q == S_ADDR && one_strobe && hit_q) begin
            is_rd_d = !rdN;
            if (WAIT_STATES > 0) begin
              cnt_d   = 4'(WAIT_STATES - 1);
              state_d = S_WAIT;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_d = S_DATA;
          else               cnt_d   = cnt_q - 4'd1;
        end
        S_DATA: begin
          wr_done_d = 1'b1;
          if (rdN && wrN) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    ready_d  = (state_d != S_WAIT);
    ad_oe_d  = (state_d == S_DATA) && is_rd_d && !rdN && !dt_rN && !denN;
    ad_out_d = ((state_d == S_DATA) && (state_q != S_DATA) && is_rd_d) ? rd_word : ad_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      bhe_n_q    <= 1'b1;
      hit_q      <= 1'b0;
      is_io_q    <= 1'b0;
      is_rd_q    <= 1'b0;
      cnt_q      <= '0;
      wr_done_q  <= 1'b0;
      both_low_q <= 1'b0;
      ready_q    <= 1'b1;
      ad_oe_q    <= 1'b0;
      err_q      <= 1'b0;
      ad_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bhe_n_q    <= bhe_n_d;
      hit_q      <= hit_d;
      is_io_q    <= is_io_d;
      is_rd_q    <= is_rd_d;
      cnt_q      <= cnt_d;
      wr_done_q  <= wr_done_d;
      both_low_q <= both_low_d;
      ready_q    <= ready_d;
      ad_oe_q    <= ad_oe_d;
      err_q      <= err_d;
      ad_out_q   <= ad_out_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (we && !is_io_q) begin
      if (!addr_q[0]) mem_q[mem_idx][7:0]  <= ad_in[7:0];
      if (!bhe_n_q)   mem_q[mem_idx][15:8] <= ad_in[15:8];
    end
  end

  assign ready  = ready_q;
  assign ad_oe  = ad_oe_q;
  assign err    = err_q;
  assign ad_out = ad_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_target_8086.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bus_target_8086 : scoreboard bench for bus_target_8086 (WAIT_STATES=2) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bus_target_8086;

  localparam int K_WAIT = 0;
  localparam int K_RD   = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          kind;
    logic [15:0] val;
    string       name;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ale = 1'b0, m_ioN = 1'b1, dt_rN = 1'b1, bheN = 1'b1;
  logic        denN = 1'b1, rdN = 1'b1, wrN = 1'b1;
  logic [3:0]  as_in = 4'h0;
  logic [15:0] ad_in = 16'h0000;
  logic [15:0] ad_out;
  logic        ad_oe, ready, err;

  ev_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  bus_target_8086 #(
    .ADDR_BITS(10), .BASE(20'h00000), .WAIT_STATES(2), .IO_BASE(16'h0000), .IO_REGS(8)
  ) dut (
    .clk(clk), .reset(reset), .ale(ale), .m_ioN(m_ioN), .dt_rN(dt_rN), .bheN(bheN),
    .denN(denN), .rdN(rdN), .wrN(wrN), .as_in(as_in), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic expect_ev(input int kind, input logic [15:0] val, input string name);
    ev_t e;
    e.kind = kind; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  task automatic check_ev(input int kind, input logic [15:0] val);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d val=%h, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val === val) n_pass++;
      else $display("FAIL %s: got kind=%0d val=%h, expected kind=%0d val=%h",
                    e.name, kind, val, e.kind, e.val);
    end
  endtask

  // Monitor: turns DUT output activity into events and matches them in order.
  initial begin
    int   lo_cnt;
    logic oe_prev;
    lo_cnt  = 0;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready === 1'b0) lo_cnt++;
      else if (lo_cnt > 0) begin
        check_ev(K_WAIT, 16'(lo_cnt));
        lo_cnt = 0;
      end
      if (ad_oe === 1'b1 && oe_prev !== 1'b1) check_ev(K_RD, ad_out);
      if (err === 1'b1) check_ev(K_ERR, 16'h0001);
      oe_prev = ad_oe;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    ale = 1'b0; rdN = 1'b1; wrN = 1'b1; denN = 1'b1; dt_rN = 1'b1;
  endtask

  task automatic addr_phase(input logic mio, input logic [19:0] a, input logic bhe);
    ale = 1'b1; m_ioN = mio; bheN = bhe; as_in = a[19:16]; ad_in = a[15:0];
    step();
    ale = 1'b0;
  endtask

  // Full bus cycle; strobe is held long enough to cover 2 wait states plus data.
  task automatic bus_cycle(input logic mio, input logic [19:0] a, input logic bhe,
                           input logic is_wr, input logic [15:0] wd,
                           input logic chk_miss, input string tag);
    addr_phase(mio, a, bhe);
    dt_rN = is_wr; denN = 1'b0;
    ad_in = is_wr ? wd : 16'h0000;
    rdN = is_wr; wrN = !is_wr;
    for (int i = 0; i < 6; i++) begin
      step();
      if (chk_miss && i == 3) begin
        chk({tag, "_ready"}, {15'd0, ready}, 16'd1);
        chk({tag, "_ad_oe"}, {15'd0, ad_oe}, 16'd0);
      end
    end
    idle_bus();
    step();
    step();
  endtask

  initial begin
    idle_bus();
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    chk("reset_ready",  {15'd0, ready}, 16'd1);
    chk("reset_ad_oe",  {15'd0, ad_oe}, 16'd0);
    chk("reset_err",    {15'd0, err},   16'd0);
    chk("reset_ad_out", ad_out,         16'h0000);

    expect_ev(K_WAIT, 16'd2, "wr_beef_wait");
    bus_cycle(1'b1, 20'h00010, 1'b0, 1'b1, 16'hBEEF, 1'b0, "wr_beef");
    expect_ev(K_WAIT, 16'd2, "rd_beef_wait");
    expect_ev(K_RD, 16'hBEEF, "rd_beef_data");
    bus_cycle(1'b1, 20'h00010, 1'b0, 1'b0, 16'h0000, 1'b0, "rd_beef");

    expect_ev(K_WAIT, 16'd2, "wr_odd_wait");
    bus_cycle(1'b1, 20'h00011, 1'b0, 1'b1, 16'h5A00, 1'b0, "wr_odd");
    expect_ev(K_WAIT, 16'd2, "rd_odd_wait");
    expect_ev(K_RD, 16'h5AEF, "rd_odd_data");
    bus_cycle(1'b1, 20'h00010, 1'b0, 1'b0, 16'h0000, 1'b0, "rd_odd");

    bus_cycle(1'b1, 20'h80000, 1'b0, 1'b0, 16'h0000, 1'b1, "miss_80000");
    bus_cycle(1'b1, 20'h00810, 1'b0, 1'b0, 16'h0000, 1'b1, "miss_00810");

    // Both strobes low: single err pulse and no write.
    addr_phase(1'b1, 20'h00010, 1'b0);
    expect_ev(K_ERR, 16'h0001, "both_low_err");
    dt_rN = 1'b1; denN = 1'b0; ad_in = 16'h0000; rdN = 1'b0; wrN = 1'b0;
    step();
    step();
    idle_bus();
    step();
    expect_ev(K_WAIT, 16'd2, "rd_after_err_wait");
    expect_ev(K_RD, 16'h5AEF, "rd_after_err_data");
    bus_cycle(1'b1, 20'h00010, 1'b0, 1'b0, 16'h0000, 1'b0, "rd_after_err");

    // Reset in WAIT: write dropped, ready back high the next cycle.
    addr_phase(1'b1, 20'h00010, 1'b0);
    expect_ev(K_WAIT, 16'd1, "rst_wait_lowcycles");
    dt_rN = 1'b1; denN = 1'b0; ad_in = 16'hDEAD; wrN = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_wait_ready", {15'd0, ready}, 16'd1);
    chk("rst_wait_ad_oe", {15'd0, ad_oe}, 16'd0);
    reset = 1'b0;
    idle_bus();
    step();
    expect_ev(K_WAIT, 16'd2, "rd_after_rst_wait");
    expect_ev(K_RD, 16'h5AEF, "rd_after_rst_data");
    bus_cycle(1'b1, 20'h00010, 1'b0, 1'b0, 16'h0000, 1'b0, "rd_after_rst");

    // A0=1 with bheN=1 is invalid: err at latch, then treated as miss.
    expect_ev(K_ERR, 16'h0001, "bad_lane_err");
    bus_cycle(1'b1, 20'h00011, 1'b1, 1'b0, 16'h0000, 1'b1, "bad_lane");

    expect_ev(K_WAIT, 16'd2, "wr_top_wait");
    bus_cycle(1'b1, 20'h007FE, 1'b0, 1'b1, 16'hA55A, 1'b0, "wr_top");
    expect_ev(K_WAIT, 16'd2, "rd_top_wait");
    expect_ev(K_RD, 16'hA55A, "rd_top_data");
    bus_cycle(1'b1, 20'h007FE, 1'b0, 1'b0, 16'h0000, 1'b0, "rd_top");

`ifdef BUS_IO_EN
    expect_ev(K_WAIT, 16'd2, "io_wr_wait");
    bus_cycle(1'b0, 20'h00004, 1'b0, 1'b1, 16'h1234, 1'b0, "io_wr");
    expect_ev(K_WAIT, 16'd2, "io_rd_wait");
    expect_ev(K_RD, 16'h1234, "io_rd_data");
    bus_cycle(1'b0, 20'h00004, 1'b0, 1'b0, 16'h0000, 1'b0, "io_rd");
`else
    bus_cycle(1'b0, 20'h00004, 1'b0, 1'b0, 16'h0000, 1'b1, "io_miss");
`endif

    repeat (4) step();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_target_8086.md
# bus_target_8086

Parametrised minimum-mode 8086 bus target that replaces ad-hoc memory stubs in CPU benches and system tops. It latches the multiplexed address on `ale` and decodes memory and optional I/O space. It generates a configurable number of wait states on `ready`, serves word/byte reads and writes from an internal RAM, and flags protocol violations. All inputs are sampled on `clk`; the bidirectional AD bus is split into in/out/enable.

## Interface
Parameters:
- `ADDR_BITS`, 10: word-address bits of internal RAM (2^ADDR_BITS 16-bit words).
- `BASE`, 20'h00000: memory window base; must be aligned to 2^(ADDR_BITS+1) bytes.
- `WAIT_STATES`, 1: wait cycles inserted per access, 0..15.
- `IO_BASE`, 16'h0000: I/O window base (only with `BUS_IO_EN`).
- `IO_REGS`, 8: number of 16-bit I/O registers, power of two.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ale` in 1: address latch enable.
- `m_ioN` in 1: 1 = memory, 0 = I/O cycle.
- `dt_rN` in 1: 0 = CPU reads.
- `bheN` in 1: high-byte enable, active-low.
- `denN` in 1: data enable, active-low.
- `rdN` in 1: read strobe, active-low.
- `wrN` in 1: write strobe, active-low.
- `as_in` in 4: A19..A16.
- `ad_in` in 16: AD15..AD0 as driven by the CPU.
- `ad_out` out 16: read data.
- `ad_oe` out 1: drive enable for `ad_out`.
- `ready` out 1: wait-state control to the CPU.
- `err` out 1: one-cycle protocol error pulse.

## Operation
- States: IDLE, ADDR, WAIT, DATA.
- IDLE: `ale`=1 → latch addr={as_in,ad_in}, `bheN`, `m_ioN`; compute hit → ADDR.
- ADDR: strobe (`rdN`=0 xor `wrN`=0) sampled with hit → WAIT (WAIT_STATES>0) or DATA. Strobe with miss → stay, no response. `ale`=1 again → relatch.
- Both `rdN` and `wrN` low in any state: `err`=1 for one cycle, no access, → IDLE.
- WAIT: down-counter loaded with WAIT_STATES; `ready`=0; at 0 → DATA.
- DATA: `ready`=1. Read: `ad_out`=mem[addr[ADDR_BITS:1]] (full word; CPU selects lanes); `ad_oe`=1 only while `rdN`=0, `dt_rN`=0 and `denN`=0. Write: on DATA entry edge, low byte written if A0=0, high byte if `bheN`=0. Strobe released → `ad_oe`=0, → IDLE.
- Memory hit: `m_ioN`=1 and addr[19:ADDR_BITS+1] == BASE[19:ADDR_BITS+1].
- Odd byte (A0=1, `bheN`=0): high lane only. A0=1 with `bheN`=1 is not a valid 8086 cycle; it is treated as a miss and raises `err`.
- `ale` in WAIT/DATA is ignored.

## Timing
- Reset values: `ready`=1, `ad_oe`=0, `ad_out`=0, `err`=0, state IDLE. RAM contents are not cleared.
- Reset mid-access: next cycle is IDLE with reset values; a write not yet reaching DATA is dropped.
- Strobe first sampled low at edge N:
  - `ready`=0 from N+1 through N+WAIT_STATES.
  - `ready`=1 and read data valid from N+1+WAIT_STATES.
  - Write committed at edge N+1+WAIT_STATES and readable in the next access.
- WAIT_STATES=0: `ready` never falls; data appears at N+1.
- Strobe sampled high at edge M in DATA → `ad_oe`=0 from M+1.
- Back-to-back: `ale` at M+1 is accepted. Minimum cycle is 3+WAIT_STATES clocks.
- Address wrap: window offsets use ADDR_BITS+1 low bits only; no carry into the decode.

## Configuration
- `BUS_IO_EN` defined:
  - I/O window of IO_REGS words at IO_BASE, decoded on `m_ioN`=0 with addr[15:log2(IO_REGS)+1] match; addr[19:16] ignored.
  - Same wait-state, lane and timing rules as memory.
  - Registers reset to 0 on `reset`.
- `BUS_IO_EN` undefined: every `m_ioN`=0 cycle is a miss (`ready`=1, `ad_oe`=0), and no I/O registers exist.

## Test plan
- Reset pulse, then idle 5 cycles → `ready`=1, `ad_oe`=0, `err`=0.
- WAIT_STATES=2, word write 16'hBEEF at 20'h00010, then read → `ready` low exactly 2 cycles per access, read `ad_out`=16'hBEEF with `ad_oe`=1.
- Byte write 8'h5A to 20'h00011 (A0=1, `bheN`=0) over 16'hBEEF → readback 16'h5AEF.
- Read at 20'h80000 with BASE=0 → `ready` stays 1, `ad_oe` stays 0.
- `rdN` and `wrN` low together → single-cycle `err`=1, no RAM change. Reset during WAIT → `ready`=1 the next cycle.
- With `BUS_IO_EN`: I/O write 16'h1234 to port 16'h0004, then read → 16'h1234. Without it: same read → no drive, `ready`=1.
